split_bus_arbiter: RTL and testbench
====================================

# split_bus_arbiter

Central arbiter for the serial bus segment that carries the bus bridge. It shares the bus between two initiators (local initiator 0 and the bridge's initiator port 1) and schedules split-transaction completions from the split-capable target (the bridge target side). It drives per-initiator grants and `split_grant`, parks one outstanding split owner, and enforces a bus-hold timeout.

## Interface
- `ROUND_ROBIN`, 0: 0 = initiator 0 has fixed priority; 1 = on tie, grant the initiator not granted last.
- `TIMEOUT_CYCLES`, 16'd1024: maximum cycles in a grant state before forced release; 0 disables the timeout.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1 each  initiator bus requests, level; held until the transaction ends.
- `ack`  in  1  target transaction-complete pulse (`target_ack`).
- `split_ack`  in  1  target split pulse (`target_split_ack`): current transaction is split.
- `split_req`  in  1  split target ready to return data, level.
- `gnt0`, `gnt1`  out  1 each  initiator grants, registered, one-hot or zero.
- `split_grant`  out  1  grant to the split target, registered.
- `owner`  out  2  0 = initiator 0, 1 = initiator 1, 3 = none.
- `split_pending`  out  1  one split transaction outstanding.
- `split_owner`  out  1  initiator that owns the outstanding split.
- `timeout`  out  1  one-cycle pulse on forced release.
- `split_err`  out  1  one-cycle pulse on a protocol violation.

## Operation
- States: IDLE, GRANT (initiator `owner` drives), SPLIT (target returns data to `split_owner`).
- IDLE priority: (1) `split_req` && `split_pending` -> SPLIT; (2) eligible requests -> GRANT. Eligible: `reqN` high and not (`split_pending` && `split_owner`==N).
- Tie with both eligible: `ROUND_ROBIN`=0 grants 0; `ROUND_ROBIN`=1 grants the initiator not granted last (`last_owner` resets to 1, so initiator 0 wins the first tie).
- GRANT exits to IDLE on: `ack`; `split_ack` (sets `split_pending`, `split_owner` <= owner); owner's `req` low; timeout.
- `ack` and `split_ack` in the same cycle: `ack` wins, no split is recorded.
- `split_ack` while `split_pending` is already set: release the bus, record nothing, pulse `split_err`.
- SPLIT: `split_grant`=1 and `gnt[split_owner]`=1, `owner`=`split_owner`. Exits to IDLE on `ack` (clears `split_pending`) or timeout (also clears `split_pending`).
- `split_req` while no split is pending is ignored and pulses `split_err` once per rising edge of `split_req`.
- `split_req` arriving during GRANT waits; it is served at the next IDLE ahead of all requests.
- Timeout counter: 16 bits, cleared on entry to GRANT or SPLIT, increments every cycle in those states. At `TIMEOUT_CYCLES`-1 it forces IDLE and pulses `timeout`.

## Timing
- Reset: state IDLE, `gnt0`=`gnt1`=`split_grant`=0, `owner`=3, `split_pending`=0, `split_owner`=0, `timeout`=0, `split_err`=0, counter 0. Reset mid-transaction drops all grants next edge and discards any pending split.
- Request visible in IDLE at edge t: grant asserted after edge t+1, one cycle latency.
- Release condition sampled at edge t: grants low after t+1. The FSM spends one IDLE cycle, so the next grant appears at t+2 at the earliest. This gives a mandatory one-cycle bus turnaround.
- `timeout` and `split_err` are high for exactly one cycle, aligned with the grant drop.
- With `TIMEOUT_CYCLES`=N, a grant is held for at most N cycles.

## Test plan
- Only `req1` high from reset: `gnt1`=1 one cycle later, `owner`=1. `ack` pulse: `gnt1` low next cycle.
- `req0` and `req1` raised together, repeated 3 times with `ROUND_ROBIN`=1: grant order is 0,1,0. With `ROUND_ROBIN`=0 the order is 0,0,0.
- Split flow: initiator 0 granted; `split_ack` -> `split_pending`=1, `split_owner`=0. `req0` stays high and is not granted while `req1` is served. `split_req` then gives `split_grant`=1 with `gnt0`=1. `ack` clears `split_pending`.
- `ack`+`split_ack` in the same cycle -> `split_pending` stays 0. A second `split_ack` while pending -> `split_err` pulse and release. `split_req` with nothing pending -> `split_err`, no grant.
- `TIMEOUT_CYCLES`=8, `req0` held with no `ack`: `gnt0` high exactly 8 cycles, `timeout` pulses, and after one IDLE cycle `gnt0` is re-granted.
- Assert `rst` while in SPLIT: next cycle all grants are 0, `split_pending`=0, `owner`=3.

Source files
------------

// File: rtl/split_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : split_bus_arbiter
// Brief    : Two-initiator bus arbiter that parks one split transaction and
//            schedules its completion, with a bus-hold timeout.
// Revision : 1.0
// ============================================================================
module split_bus_arbiter #(
    parameter bit          ROUND_ROBIN    = 1'b0,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       ack,
    input  logic       split_ack,
    input  logic       split_req,
    output logic       gnt0,
    output logic       gnt1,
    output logic       split_grant,
    output logic [1:0] owner,
    output logic       split_pending,
    output logic       split_owner,
    output logic       timeout,
    output logic       split_err
);

    localparam logic [1:0]  c_owner_none = 2'd3;
    localparam logic [15:0] c_count_last = TIMEOUT_CYCLES - 16'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_SPLIT = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_count;
    logic        r_cur;
    logic        r_last_owner;
    logic        r_split_req_d;

    logic w_elig0;
    logic w_elig1;
    logic w_pick;
    logic w_owner_req;
    logic w_limit;
    logic w_sreq_rise;

    // An initiator whose transaction is parked as a split may not start another.
    assign w_elig0     = req0 && !(split_pending && (split_owner == 1'b0));
    assign w_elig1     = req1 && !(split_pending && (split_owner == 1'b1));
    assign w_pick      = (w_elig0 && w_elig1) ? (ROUND_ROBIN ? ~r_last_owner : 1'b0)
                                              : w_elig1;
    assign w_owner_req = r_cur ? req1 : req0;
    assign w_limit     = (TIMEOUT_CYCLES != 16'd0) && (r_count == c_count_last);
    assign w_sreq_rise = split_req && !r_split_req_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_count       <= 16'd0;
            r_cur         <= 1'b0;
            r_last_owner  <= 1'b1;
            r_split_req_d <= 1'b0;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            split_grant   <= 1'b0;
            owner         <= c_owner_none;
            split_pending <= 1'b0;
            split_owner   <= 1'b0;
            timeout       <= 1'b0;
            split_err     <= 1'b0;
        end else begin
            r_split_req_d <= split_req;
            timeout       <= 1'b0;
            split_err     <= w_sreq_rise && !split_pending;

            case (r_state)
                S_IDLE: begin
                    if (split_req && split_pending) begin
                        r_state     <= S_SPLIT;
                        r_count     <= 16'd0;
                        split_grant <= 1'b1;
                        gnt0        <= ~split_owner;
                        gnt1        <= split_owner;
                        owner       <= {1'b0, split_owner};
                    end else if (w_elig0 || w_elig1) begin
                        r_state      <= S_GRANT;
                        r_count      <= 16'd0;
                        r_cur        <= w_pick;
                        r_last_owner <= w_pick;
                        gnt0         <= ~w_pick;
                        gnt1         <= w_pick;
                        owner        <= {1'b0, w_pick};
                    end
                end

                S_GRANT: begin
                    if (ack || split_ack || !w_owner_req || w_limit) begin
                        r_state <= S_IDLE;
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        owner   <= c_owner_none;
                        // ack dominates split_ack; a second split cannot be parked.
                        if (!ack && split_ack) begin
                            if (split_pending) begin
                                split_err <= 1'b1;
                            end else begin
                                split_pending <= 1'b1;
                                split_owner   <= r_cur;
                            end
                        end
                        if (!ack && !split_ack && w_owner_req) begin
                            timeout <= 1'b1;
                        end
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end

                S_SPLIT: begin
                    if (ack || w_limit) begin
                        r_state       <= S_IDLE;
                        gnt0          <= 1'b0;
                        gnt1          <= 1'b0;
                        split_grant   <= 1'b0;
                        owner         <= c_owner_none;
                        split_pending <= 1'b0;
                        timeout       <= !ack;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    gnt0        <= 1'b0;
                    gnt1        <= 1'b0;
                    split_grant <= 1'b0;
                    owner       <= c_owner_none;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_split_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_split_bus_arbiter
// Brief    : Self-checking bench: fixed-priority/no-timeout and
//            round-robin/8-cycle-timeout arbiters against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_split_bus_arbiter;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic req0      = 1'b0;
    logic req1      = 1'b0;
    logic ack       = 1'b0;
    logic split_ack = 1'b0;
    logic split_req = 1'b0;

    logic [1:0] gnt0_o, gnt1_o, sg_o, pend_o, sown_o, to_o, err_o;
    logic [1:0] own_o [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        split_bus_arbiter #(
            .ROUND_ROBIN   (g == 1),
            .TIMEOUT_CYCLES((g == 1) ? 16'd8 : 16'd0)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req0         (req0),
            .req1         (req1),
            .ack          (ack),
            .split_ack    (split_ack),
            .split_req    (split_req),
            .gnt0         (gnt0_o[g]),
            .gnt1         (gnt1_o[g]),
            .split_grant  (sg_o[g]),
            .owner        (own_o[g]),
            .split_pending(pend_o[g]),
            .split_owner  (sown_o[g]),
            .timeout      (to_o[g]),
            .split_err    (err_o[g])
        );
    end

    // Model: who holds the bus (-1 none), whether it is a split completion,
    // and how many cycles it has been held so far.
    int m_holder [2] = '{-1, -1};
    bit m_split  [2] = '{1'b0, 1'b0};
    int m_held   [2] = '{0, 0};
    bit m_pend   [2] = '{1'b0, 1'b0};
    bit m_sown   [2] = '{1'b0, 1'b0};
    bit m_last   [2] = '{1'b1, 1'b1};
    bit m_prev   [2] = '{1'b0, 1'b0};
    bit m_to     [2] = '{1'b0, 1'b0};
    bit m_err    [2] = '{1'b0, 1'b0};
    bit c_rr     [2] = '{1'b0, 1'b1};
    int c_lim    [2] = '{0, 8};

    always @(posedge clk) begin
        bit e0, e1, held_out, own_req;
        int pick;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_holder[i] = -1; m_split[i] = 1'b0; m_held[i] = 0;
                m_pend[i] = 1'b0; m_sown[i] = 1'b0; m_last[i] = 1'b1;
                m_prev[i] = 1'b0; m_to[i] = 1'b0; m_err[i] = 1'b0;
            end else begin
                m_to[i]  = 1'b0;
                m_err[i] = split_req && !m_prev[i] && !m_pend[i];
                held_out = (c_lim[i] != 0) && (m_held[i] == c_lim[i]);
                if (m_holder[i] < 0) begin
                    e0 = req0 && !(m_pend[i] && m_sown[i] == 1'b0);
                    e1 = req1 && !(m_pend[i] && m_sown[i] == 1'b1);
                    if (split_req && m_pend[i]) begin
                        m_holder[i] = int'(m_sown[i]); m_split[i] = 1'b1; m_held[i] = 1;
                    end else if (e0 || e1) begin
                        if (e0 && e1) pick = c_rr[i] ? (1 - int'(m_last[i])) : 0;
                        else          pick = e0 ? 0 : 1;
                        m_holder[i] = pick; m_split[i] = 1'b0; m_held[i] = 1;
                        m_last[i]   = (pick == 1);
                    end
                end else if (!m_split[i]) begin
                    own_req = (m_holder[i] == 1) ? req1 : req0;
                    if (ack || split_ack || !own_req || held_out) begin
                        if (!ack && split_ack) begin
                            if (m_pend[i]) m_err[i] = 1'b1;
                            else begin m_pend[i] = 1'b1; m_sown[i] = (m_holder[i] == 1); end
                        end
                        m_to[i]     = !ack && !split_ack && own_req;
                        m_holder[i] = -1;
                    end else begin
                        m_held[i]++;
                    end
                end else begin
                    if (ack || held_out) begin
                        m_to[i]     = !ack;
                        m_pend[i]   = 1'b0;
                        m_holder[i] = -1;
                        m_split[i]  = 1'b0;
                    end else begin
                        m_held[i]++;
                    end
                end
                m_prev[i] = split_req;
            end
        end
    end

    function automatic logic [8:0] model_vec(int i);
        logic [1:0] own;
        own = (m_holder[i] < 0) ? 2'd3 : 2'(m_holder[i]);
        return {m_holder[i] == 0, m_holder[i] == 1, m_split[i] && (m_holder[i] >= 0),
                own, m_pend[i], m_sown[i], m_to[i], m_err[i]};
    endfunction

    function automatic logic [8:0] dut_vec(int i);
        return {gnt0_o[i], gnt1_o[i], sg_o[i], own_o[i], pend_o[i], sown_o[i], to_o[i], err_o[i]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++)
            chk($sformatf("cycle_dut%0d", i), 32'(dut_vec(i)), 32'(model_vec(i)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;

        tick(); tick();
        for (int i = 0; i < 2; i++) chk($sformatf("reset_%0d", i), 32'(dut_vec(i)), 32'h030);
        rst = 1'b0;

        // Lone request from initiator 1, then completion.
        req1 = 1'b1; tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("solo_gnt1_%0d", i), gnt1_o[i], 1);
            chk($sformatf("solo_owner_%0d", i), own_o[i], 1);
        end
        ack = 1'b1; tick(); ack = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 2; i++) chk($sformatf("solo_drop_%0d", i), gnt1_o[i], 0);
        tick();

        // Three simultaneous ties: fixed priority 0,0,0; round robin 0,1,0.
        for (int k = 0; k < 3; k++) begin
            req0 = 1'b1; req1 = 1'b1; tick();
            chk($sformatf("tie%0d_fixed", k), gnt0_o[0], 1);
            chk($sformatf("tie%0d_rr", k), gnt0_o[1], (k % 2 == 0) ? 1 : 0);
            ack = 1'b1; tick(); ack = 1'b0; req0 = 1'b0; req1 = 1'b0; tick();
        end

        // Split flow owned by initiator 0.
        req0 = 1'b1; tick();
        split_ack = 1'b1; tick(); split_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("split_pend_%0d", i), pend_o[i], 1);
            chk($sformatf("split_own_%0d", i), sown_o[i], 0);
        end
        chk("model_pend", 32'(m_pend[1]), 1);
        req1 = 1'b1; tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("split_block0_%0d", i), gnt0_o[i], 0);
            chk($sformatf("split_serve1_%0d", i), gnt1_o[i], 1);
        end
        ack = 1'b1; tick(); ack = 1'b0; req1 = 1'b0;
        split_req = 1'b1; tick();
        for (int i = 0; i < 2; i++)
            chk($sformatf("split_grant_%0d", i), {sg_o[i], gnt0_o[i], own_o[i]}, 4'b1100);
        ack = 1'b1; tick(); ack = 1'b0; split_req = 1'b0; req0 = 1'b0;
        for (int i = 0; i < 2; i++) chk($sformatf("split_clear_%0d", i), pend_o[i], 0);
        tick();

        // ack and split_ack together record nothing.
        req1 = 1'b1; tick();
        ack = 1'b1; split_ack = 1'b1; tick(); ack = 1'b0; split_ack = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 2; i++) chk($sformatf("ack_wins_%0d", i), pend_o[i], 0);
        tick();

        // Second split while one is parked.
        req0 = 1'b1; tick();
        split_ack = 1'b1; tick(); split_ack = 1'b0; req0 = 1'b0; req1 = 1'b1; tick();
        split_ack = 1'b1; tick(); split_ack = 1'b0; req1 = 1'b0;
        for (int i = 0; i < 2; i++)
            chk($sformatf("dbl_split_%0d", i), {err_o[i], gnt1_o[i], pend_o[i], sown_o[i]}, 4'b1010);
        tick();
        for (int i = 0; i < 2; i++) chk($sformatf("dbl_err_end_%0d", i), err_o[i], 0);
        split_req = 1'b1; tick();
        ack = 1'b1; tick(); ack = 1'b0; split_req = 1'b0; tick();

        // split_req with nothing parked.
        split_req = 1'b1; tick();
        for (int i = 0; i < 2; i++)
            chk($sformatf("stray_sreq_%0d", i), {err_o[i], sg_o[i], gnt0_o[i], gnt1_o[i]}, 4'b1000);
        tick();
        for (int i = 0; i < 2; i++) chk($sformatf("stray_once_%0d", i), err_o[i], 0);
        split_req = 1'b0; tick();

        // Hold timeout on the 8-cycle instance.
        req0 = 1'b1; tick();
        cnt = 0;
        while (gnt0_o[1] && cnt < 20) begin cnt++; tick(); end
        chk("to_hold_cycles", cnt, 8);
        chk("to_pulse", to_o[1], 1);
        chk("to_drop", gnt0_o[1], 0);
        tick();
        chk("to_regrant", gnt0_o[1], 1);
        chk("to_pulse_end", to_o[1], 0);
        chk("no_to_hold", gnt0_o[0], 1);

        // Reset while serving a split completion.
        split_ack = 1'b1; tick(); split_ack = 1'b0; req0 = 1'b0; split_req = 1'b1; tick();
        for (int i = 0; i < 2; i++) chk($sformatf("pre_rst_split_%0d", i), sg_o[i], 1);
        rst = 1'b1; tick();
        for (int i = 0; i < 2; i++) chk($sformatf("rst_in_split_%0d", i), 32'(dut_vec(i)), 32'h030);
        rst = 1'b0; split_req = 1'b0; tick();

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) req0 = ~req0;
            if ($urandom_range(0, 7) == 0) req1 = ~req1;
            if ($urandom_range(0, 9) == 0) split_req = ~split_req;
            ack       = ($urandom_range(0, 5) == 0);
            split_ack = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; ack = 1'b0; split_ack = 1'b0; split_req = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
